// File: rtl/pixel_blend_alu.sv
// pixel_blend_alu: two-stage valid/ready pipeline applying per-channel saturating add/sub, average or accumulate
module pixel_blend_alu #(
    parameter int CH_W = 2,
    parameter int NUM_CH = 3,
    parameter int SATC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_mode,
    input  logic [NUM_CH*CH_W-1:0]   in_a,
    input  logic [NUM_CH*CH_W-1:0]   in_b,
    input  logic                     acc_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*CH_W-1:0]   out_pix,
    output logic                     out_sat,
    output logic [SATC_W-1:0]        sat_cnt
);
    localparam int PW = NUM_CH * CH_W;
    logic s1_valid, adv1, adv2, is_acc;
    logic [1:0] s1_mode;
    logic [PW-1:0] s1_a, s1_b, acc, res;
    logic [NUM_CH-1:0] sat_ch;
    logic [CH_W-1:0] ca, cb;
    logic [CH_W:0] sum, diff;
    assign adv2 = !out_valid || out_ready;
    assign adv1 = s1_valid && adv2;
    assign in_ready = rst_n && (!s1_valid || adv2);
    assign is_acc = s1_mode == 2'd3;
    // ACC reuses the ADD datapath with the accumulator as the first operand and a as the second
    always_comb begin
        res = '0;
        sat_ch = '0;
        ca = '0;
        cb = '0;
        sum = '0;
        diff = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ca = is_acc ? (acc_clr ? '0 : acc[i*CH_W +: CH_W]) : s1_a[i*CH_W +: CH_W];
            cb = is_acc ? s1_a[i*CH_W +: CH_W] : s1_b[i*CH_W +: CH_W];
            sum = {1'b0, ca} + {1'b0, cb};
            diff = {1'b0, ca} - {1'b0, cb};
            sat_ch[i] = s1_mode == 2'd1 ? diff[CH_W] : s1_mode == 2'd2 ? 1'b0 : sum[CH_W];
            res[i*CH_W +: CH_W] = s1_mode == 2'd1 ? (diff[CH_W] ? '0 : diff[CH_W-1:0]) :
                                  s1_mode == 2'd2 ? sum[CH_W:1] :
                                  (sum[CH_W] ? '1 : sum[CH_W-1:0]);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode <= '0;
            s1_a <= '0;
            s1_b <= '0;
            out_valid <= 1'b0;
            out_pix <= '0;
            out_sat <= 1'b0;
            sat_cnt <= '0;
            acc <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_mode <= in_mode;
                    s1_a <= in_a;
                    s1_b <= in_b;
                end
            end
            if (adv2) out_valid <= s1_valid;
            if (adv1) begin
                out_pix <= res;
                out_sat <= |sat_ch;
            end
            if (adv1 && is_acc) acc <= res;
            else if (acc_clr) acc <= '0;
            if (out_valid && out_ready && out_sat && sat_cnt != '1) sat_cnt <= sat_cnt + 1'b1;
        end
    end
endmodule

// File: doc/pixel_blend_alu.md
# pixel_blend_alu

Parametrised, pipelined per-channel pixel arithmetic unit for the badGPU datapath, successor to the top-level combinational adder. Takes two packed pixels per beat over a valid/ready handshake and applies a per-beat operation to each colour channel independently: saturating add, saturating subtract, average, or accumulate. Sits between the pixel source (rasteriser/shader stage) and the output formatter that drives `uo_out`. Throughput is one beat per cycle; latency is 2 cycles.

## Interface
- `CH_W`, default 2: bits per colour channel (≥1).
- `NUM_CH`, default 3: channels per pixel (≥1); pixel width `PW = NUM_CH*CH_W`.
- `SATC_W`, default 8: width of the saturation event counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  unit accepts a beat this cycle.
- `in_mode`  in  2  operation for this beat: 0 ADD, 1 SUB, 2 AVG, 3 ACC.
- `in_a`  in  PW  operand A; channel i = bits `[i*CH_W +: CH_W]`.
- `in_b`  in  PW  operand B, same packing (ignored in ACC).
- `acc_clr`  in  1  clear all channel accumulators.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  downstream accepts result.
- `out_pix`  out  PW  result pixel, same packing.
- `out_sat`  out  1  at least one channel of this result saturated.
- `sat_cnt`  out  SATC_W  count of saturated result beats.

## Operation
- Two register stages: S1 (operand capture: a, b, mode) and S2 (result: pix, sat).
- Transfer rules: input handshake = `in_valid && in_ready`; output handshake = `out_valid && out_ready`.
- `adv2 = !s2_valid || out_ready`; `adv1 = s1_valid && adv2`; `in_ready = rst_n && (!s1_valid || adv2)`. Ready path combinational; no bubbles when `out_ready` held high.
- Per channel, in S1→S2 transfer, unsigned CH_W operands, computed at CH_W+1 bits:
  - ADD: `a+b`; if > 2^CH_W−1, result = 2^CH_W−1, channel saturated.
  - SUB: `a−b`; if a < b, result = 0, channel saturated.
  - AVG: `(a+b)>>1` (truncating); never saturates.
  - ACC: `acc[i]+a` saturated as ADD; `acc[i]` <= result. b ignored.
- `acc[i]` (CH_W bits each) updates only on an ACC beat advancing S1→S2.
- `acc_clr` high: accumulators read as 0 for a same-cycle ACC beat (result = a, acc <= a); otherwise accumulators <= 0. Clear has priority over non-ACC state, never stalls the pipe.
- `out_sat` = OR of channel saturation flags, registered with `out_pix`.
- `sat_cnt` increments by 1 on each output handshake with `out_sat`=1; holds at 2^SATC_W−1 (no wrap). Cleared only by reset.
- While `out_valid && !out_ready`: `out_pix`, `out_sat` hold stable; S1 holds if full; `in_ready` low when both stages full.

## Timing
- Reset (sampled on edge with `rst_n`=0): s1_valid=0, out_valid=0, out_pix=0, out_sat=0, sat_cnt=0, all acc=0; `in_ready`=0 while `rst_n` low, 1 on first cycle after release.
- Reset mid-operation: in-flight beats discarded, no output handshake occurs for them.
- Latency: beat accepted at edge N appears with `out_valid`=1 after edge N+2 (stall-free).
- Simultaneous input and output handshake with both stages full: S2 takes S1, S1 takes new beat, no loss.
- Back-to-back ACC beats: each sees accumulator written by the previous beat (no hazard; update happens in the same transfer).

## Test plan
- Reset: hold `rst_n`=0 3 cycles with `in_valid`=1 → out_valid=0, out_pix=0, sat_cnt=0, in_ready=0; first cycle after release in_ready=1.
- ADD/SUB saturation (CH_W=2, NUM_CH=3): a=0x39 {3,2,1}, b=0x15 {1,1,1}, ADD → out_pix=0x3E {3,3,2}, out_sat=1; SUB a=0x06, b=0x19 → 0x01 {0,0,1}, out_sat=1; sat_cnt=2.
- AVG: a=0x3F, b=0x00 → out_pix=0x15 {1,1,1}, out_sat=0; exactly 2 cycles after accept.
- ACC: acc_clr with first of four ACC beats a=0x15 → outputs 0x15, 0x2A, 0x3F, 0x3F (last sat=1); acc_clr next idle cycle, ACC a=0x01 → 0x01.
- Backpressure: stream 10 ADD beats, `out_ready` random 50%; scoreboard order and values exact, no drops/duplicates, out_pix stable while stalled, in_ready=0 when both stages full.
- Counter saturation (SATC_W=2): 5 saturating beats → sat_cnt 1,2,3,3,3.
